// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write, read and status signals of the dual-write-port register file
interface regfile_mp_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          D_En;
  logic [AW-1:0] D_Addr;
  logic [DW-1:0] D;
  logic          E_En;
  logic [AW-1:0] E_Addr;
  logic [DW-1:0] E;
  logic [AW-1:0] S_Addr;
  logic [AW-1:0] T_Addr;
  logic [DW-1:0] S;
  logic [DW-1:0] T;
  logic          busy;
  modport master (
    output D_En, D_Addr, D, E_En, E_Addr, E, S_Addr, T_Addr,
    input  S, T, busy
  );
  modport slave (
    input  D_En, D_Addr, D, E_En, E_Addr, E, S_Addr, T_Addr,
    output S, T, busy
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: 2-read/2-write register file with a post-reset clear sweep, optional zero entry and forwarding
module regfile_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic        clk,
  input logic        reset,
  regfile_mp_if.slave bus
);
  typedef enum logic {CLEAR, READY} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic          busy_q, busy_d;
  logic          clr_we, d_we, e_we;
  logic [DW-1:0] mem [2**AW];
  // next state of the clear engine; the index holds at its terminal count instead of wrapping
  always_comb begin
    state_d   = reset ? CLEAR : (state_q == CLEAR && clr_idx_q == '1) ? READY : state_q;
    clr_idx_d = reset ? '0 : (state_q == CLEAR && clr_idx_q != '1) ? clr_idx_q + 1'b1 : clr_idx_q;
    busy_d    = state_d == CLEAR;
    clr_we    = !reset && state_q == CLEAR;
    e_we      = !reset && state_q == READY && bus.E_En && !(ZERO_REG && bus.E_Addr == '0);
    d_we      = !reset && state_q == READY && bus.D_En && !(ZERO_REG && bus.D_Addr == '0)
                && !(bus.E_En && bus.E_Addr == bus.D_Addr);
  end
  // state, sweep index and registered busy flag
  always_ff @(posedge clk) begin
    state_q   <= state_d;
    clr_idx_q <= clr_idx_d;
    busy_q    <= busy_d;
  end
  // storage has no reset of its own; the sweep zeroes it one entry per edge
  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_idx_q] <= '0;
    if (d_we) mem[bus.D_Addr] <= bus.D;
    if (e_we) mem[bus.E_Addr] <= bus.E;
  end
  assign bus.busy = busy_q;
  assign bus.S = (busy_q || (ZERO_REG && bus.S_Addr == '0)) ? '0
               : (BYPASS && bus.E_En && bus.E_Addr == bus.S_Addr) ? bus.E
               : (BYPASS && bus.D_En && bus.D_Addr == bus.S_Addr) ? bus.D
               : mem[bus.S_Addr];
  assign bus.T = (busy_q || (ZERO_REG && bus.T_Addr == '0)) ? '0
               : (BYPASS && bus.E_En && bus.E_Addr == bus.T_Addr) ? bus.E
               : (BYPASS && bus.D_En && bus.D_Addr == bus.T_Addr) ? bus.D
               : mem[bus.T_Addr];
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of a default instance and a ZERO_REG=0/BYPASS=0 instance
module tb_regfile_mp;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  regfile_mp_if #(.DW(32), .AW(5)) ifa ();
  regfile_mp_if #(.DW(32), .AW(5)) ifb ();
  regfile_mp u_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  regfile_mp #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_b (.clk(clk), .reset(reset), .bus(ifb.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic den, input logic [4:0] dad, input logic [31:0] d,
                       input logic een, input logic [4:0] ead, input logic [31:0] e,
                       input logic [4:0] sa, input logic [4:0] ta);
    ifa.D_En = den; ifa.D_Addr = dad; ifa.D = d; ifa.E_En = een; ifa.E_Addr = ead; ifa.E = e;
    ifa.S_Addr = sa; ifa.T_Addr = ta;
    ifb.D_En = den; ifb.D_Addr = dad; ifb.D = d; ifb.E_En = een; ifb.E_Addr = ead; ifb.E = e;
    ifb.S_Addr = sa; ifb.T_Addr = ta;
    #1;
  endtask
  initial begin
    int n;
    drive(0, 5'd0, 0, 0, 5'd0, 0, 5'd1, 5'd2);
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_busy_a", 32'(ifa.busy), 32'd1);
    chk("rst_busy_b", 32'(ifb.busy), 32'd1);
    chk("rst_S_a", ifa.S, 32'd0);
    chk("rst_T_b", ifb.T, 32'd0);
    reset = 1'b0;
    n = 0;
    while (ifa.busy && n < 100) begin
      tick();
      n++;
    end
    chk("sweep_len", 32'(n), 32'd32);
    chk("sweep_busy_b", 32'(ifb.busy), 32'd0);
    for (int i = 0; i < 32; i++) begin
      drive(0, 5'd0, 0, 0, 5'd0, 0, 5'(i), 5'(31 - i));
      chk("clr_S_a", ifa.S, 32'd0);
      chk("clr_T_a", ifa.T, 32'd0);
      chk("clr_S_b", ifb.S, 32'd0);
      chk("clr_T_b", ifb.T, 32'd0);
    end
    drive(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 0, 5'd5, 5'd0);
    chk("wr_fwd_a", ifa.S, 32'hDEADBEEF);
    chk("wr_nofwd_b", ifb.S, 32'd0);
    tick();
    drive(0, 5'd0, 0, 0, 5'd0, 0, 5'd5, 5'd0);
    chk("wr_rd_a", ifa.S, 32'hDEADBEEF);
    chk("wr_rd_b", ifb.S, 32'hDEADBEEF);
    drive(1, 5'd7, 32'h11111111, 1, 5'd7, 32'h22222222, 5'd0, 5'd7);
    chk("col_fwd_a", ifa.T, 32'h22222222);
    chk("col_nofwd_b", ifb.T, 32'd0);
    tick();
    drive(0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 5'd7);
    chk("col_rd_a", ifa.T, 32'h22222222);
    chk("col_rd_b", ifb.T, 32'h22222222);
    drive(0, 5'd0, 0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5);
    chk("zero_fwd_a", ifa.S, 32'd0);
    chk("zero_same_b", ifb.S, 32'd0);
    tick();
    drive(0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 5'd5);
    chk("zero_rd_a", ifa.S, 32'd0);
    chk("zero_rd_b", ifb.S, 32'hFFFFFFFF);
    chk("keep5_a", ifa.T, 32'hDEADBEEF);
    drive(1, 5'd9, 32'h12345678, 0, 5'd0, 0, 5'd9, 5'd9);
    chk("byp_fwd_a", ifa.S, 32'h12345678);
    chk("byp0_same_b", ifb.S, 32'd0);
    tick();
    drive(0, 5'd0, 0, 0, 5'd0, 0, 5'd9, 5'd9);
    chk("byp_rd_a", ifa.T, 32'h12345678);
    chk("byp0_next_b", ifb.S, 32'h12345678);
    reset = 1'b1;
    drive(1, 5'd9, 32'hCAFEF00D, 0, 5'd0, 0, 5'd9, 5'd9);
    tick();
    reset = 1'b0;
    drive(0, 5'd0, 0, 0, 5'd0, 0, 5'd3, 5'd9);
    chk("re_busy_a", 32'(ifa.busy), 32'd1);
    chk("re_S_forced", ifa.S, 32'd0);
    repeat (10) tick();
    chk("mid_busy_a", 32'(ifa.busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n = 0;
    while (ifa.busy && n < 100) begin
      drive(0, 5'd0, 0, n == 20, 5'd3, 32'hAAAAAAAA, 5'd3, 5'd9);
      tick();
      n++;
    end
    chk("mid_sweep_len", 32'(n), 32'd32);
    drive(0, 5'd0, 0, 0, 5'd0, 0, 5'd3, 5'd9);
    chk("mid_drop_a", ifa.S, 32'd0);
    chk("mid_drop_b", ifb.S, 32'd0);
    chk("mid_clr9_a", ifa.T, 32'd0);
    chk("mid_clr9_b", ifb.T, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
